// File: rtl/ahb2apb_bridge_param.sv
// AHB-lite slave to APB master bridge, parametrised width and slave count, with
// wait states, slave error and decode-miss ERROR. Optional ACCESS timeout: AHB2APB_TIMEOUT_EN.
module ahb2apb_bridge_param #(
    parameter int unsigned         ADDR_W      = 32,
    parameter int unsigned         DATA_W      = 32,
    parameter int unsigned         NUM_SLAVES  = 3,
    parameter logic [ADDR_W-1:0]   BASE_ADDR   = ADDR_W'(32'h8000_0000),
    parameter int unsigned         REGION_BITS = 26,
    parameter int unsigned         TIMEOUT     = 16
) (
    input  logic                  Hclk,
    input  logic                  Hresetn,
    input  logic                  Hwrite,
    input  logic                  Hreadyin,
    input  logic [1:0]            Htrans,
    input  logic [ADDR_W-1:0]     Haddr,
    input  logic [DATA_W-1:0]     Hwdata,
    output logic                  Hreadyout,
    output logic [1:0]            Hresp,
    output logic [DATA_W-1:0]     Hrdata,
    output logic [NUM_SLAVES-1:0] Pselx,
    output logic                  Penable,
    output logic                  Pwrite,
    output logic [ADDR_W-1:0]     Paddr,
    output logic [DATA_W-1:0]     Pwdata,
    input  logic [DATA_W-1:0]     Prdata,
    input  logic                  Pready,
    input  logic                  Pslverr
);

    localparam int unsigned IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

    typedef enum logic [2:0] {
        IDLE,
        WDATA,
        SETUP,
        ACCESS,
        ERR1,
        ERR2
    } state_t;

    state_t                  state;
    state_t                  state_n;
    logic                    valid;
    logic                    hit;
    logic                    accept;
    logic                    timed_out;
    logic [ADDR_W-1:0]       off;
    logic [ADDR_W-1:0]       region;
    logic [IDX_W-1:0]        dec_idx;
    logic [IDX_W-1:0]        idx_q;
    logic [IDX_W-1:0]        sel_idx;
    logic [NUM_SLAVES-1:0]   sel_onehot;
    logic                    unused_ok;

    assign unused_ok = ^{Htrans[0], 32'(TIMEOUT)};

    assign valid   = Hreadyin & Htrans[1];
    assign off     = Haddr - BASE_ADDR;
    assign region  = off >> REGION_BITS;
    assign hit     = (Haddr >= BASE_ADDR) && (region < ADDR_W'(NUM_SLAVES));
    assign dec_idx = region[IDX_W-1:0];
    assign accept  = (state == IDLE) && valid && hit;

    // A read goes straight from IDLE to SETUP, so the select must come from the live decode there.
    always_comb begin
        sel_idx    = (state == IDLE) ? dec_idx : idx_q;
        sel_onehot = '0;
        for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
            sel_onehot[i] = (sel_idx == IDX_W'(i));
        end
    end

`ifdef AHB2APB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] wait_cnt;

    // Abort on the edge where the TIMEOUT-th Pready-low cycle is counted.
    assign timed_out = (wait_cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            wait_cnt <= '0;
        end else if (state == SETUP) begin
            wait_cnt <= '0;
        end else if ((state == ACCESS) && !Pready) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end
`else
    assign timed_out = 1'b0;
`endif

    always_comb begin
        state_n = state;
        case (state)
            IDLE: begin
                if (valid) begin
                    if (!hit) begin
                        state_n = ERR1;
                    end else if (Hwrite) begin
                        state_n = WDATA;
                    end else begin
                        state_n = SETUP;
                    end
                end
            end
            WDATA:  state_n = SETUP;
            SETUP:  state_n = ACCESS;
            ACCESS: begin
                if (Pready) begin
                    state_n = Pslverr ? ERR1 : IDLE;
                end else if (timed_out) begin
                    state_n = ERR1;
                end
            end
            ERR1:    state_n = ERR2;
            ERR2:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            state     <= IDLE;
            Hreadyout <= 1'b1;
            Hresp     <= 2'b00;
            Hrdata    <= '0;
            Pselx     <= '0;
            Penable   <= 1'b0;
            Pwrite    <= 1'b0;
            Paddr     <= '0;
            Pwdata    <= '0;
            idx_q     <= '0;
        end else begin
            state     <= state_n;
            Hreadyout <= (state_n == IDLE) || (state_n == ERR2);
            Hresp     <= ((state_n == ERR1) || (state_n == ERR2)) ? 2'b01 : 2'b00;
            Pselx     <= ((state_n == SETUP) || (state_n == ACCESS)) ? sel_onehot : '0;
            Penable   <= (state_n == ACCESS);
            if (accept) begin
                Paddr  <= Haddr;
                Pwrite <= Hwrite;
                idx_q  <= dec_idx;
            end
            if (state == WDATA) begin
                Pwdata <= Hwdata;
            end
            if ((state == ACCESS) && (state_n == IDLE) && !Pwrite) begin
                Hrdata <= Prdata;
            end
        end
    end

endmodule

// File: tb/tb_ahb2apb_bridge_param.sv
// Directed, table-driven bench for ahb2apb_bridge_param (3 slaves at 0x8000_0000, 64 MB regions).
module tb_ahb2apb_bridge_param;

    logic        Hclk;
    logic        Hresetn;
    logic        Hwrite;
    logic        Hreadyin;
    logic [1:0]  Htrans;
    logic [31:0] Haddr;
    logic [31:0] Hwdata;
    logic        Hreadyout;
    logic [1:0]  Hresp;
    logic [31:0] Hrdata;
    logic [2:0]  Pselx;
    logic        Penable;
    logic        Pwrite;
    logic [31:0] Paddr;
    logic [31:0] Pwdata;
    logic [31:0] Prdata;
    logic        Pready;
    logic        Pslverr;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_paddr = 32'h0;

    ahb2apb_bridge_param #(
        .ADDR_W     (32),
        .DATA_W     (32),
        .NUM_SLAVES (3),
        .BASE_ADDR  (32'h8000_0000),
        .REGION_BITS(26),
        .TIMEOUT    (16)
    ) dut (
        .Hclk     (Hclk),
        .Hresetn  (Hresetn),
        .Hwrite   (Hwrite),
        .Hreadyin (Hreadyin),
        .Htrans   (Htrans),
        .Haddr    (Haddr),
        .Hwdata   (Hwdata),
        .Hreadyout(Hreadyout),
        .Hresp    (Hresp),
        .Hrdata   (Hrdata),
        .Pselx    (Pselx),
        .Penable  (Penable),
        .Pwrite   (Pwrite),
        .Paddr    (Paddr),
        .Pwdata   (Pwdata),
        .Prdata   (Prdata),
        .Pready   (Pready),
        .Pslverr  (Pslverr)
    );

    initial Hclk = 1'b0;
    always #5 Hclk = ~Hclk;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] prdata;
        int          waits;
        logic        slverr;
        logic        hit;
        logic [2:0]  sel;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[9];

    task automatic tick();
        @(posedge Hclk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v);
        Hwrite = v.wr; Haddr = v.addr; Htrans = 2'b10; Hreadyin = 1'b1;
        Pready = 1'b0; Pslverr = 1'b0;
        tick();
        Htrans = 2'b00; Haddr = 32'h0; Hwdata = v.wdata;
        check("ready_after_accept", Hreadyout, 1'b0);
        if (!v.hit) begin
            check("miss_resp1", Hresp, 2'b01);
            check("miss_sel", Pselx, 3'b000);
            check("miss_paddr_hold", Paddr, exp_paddr);
            tick();
            check("miss_resp2", Hresp, 2'b01);
            check("miss_ready2", Hreadyout, 1'b1);
            tick();
            check("miss_okay", Hresp, 2'b00);
            check("miss_ready_idle", Hreadyout, 1'b1);
        end else begin
            if (v.wr) begin
                check("wdata_sel", Pselx, 3'b000);
                tick();
                Hwdata = ~v.wdata;
            end
            check("setup_sel", Pselx, v.sel);
            check("setup_penable", Penable, 1'b0);
            check("setup_paddr", Paddr, v.addr);
            check("setup_pwrite", Pwrite, v.wr);
            check("setup_ready", Hreadyout, 1'b0);
            exp_paddr = v.addr;
            tick();
            check("access_penable", Penable, 1'b1);
            check("access_sel", Pselx, v.sel);
            check("access_ready", Hreadyout, 1'b0);
            if (v.wr) check("access_pwdata", Pwdata, v.wdata);
            for (int w = 0; w < v.waits; w++) begin
                tick();
                check("wait_penable", Penable, 1'b1);
                check("wait_ready", Hreadyout, 1'b0);
            end
            Pready = 1'b1; Prdata = v.prdata; Pslverr = v.slverr;
            tick();
            Pready = 1'b0; Pslverr = 1'b0; Prdata = 32'h0BAD_0BAD;
            check("done_sel", Pselx, 3'b000);
            check("done_penable", Penable, 1'b0);
            if (v.slverr) begin
                check("slverr_resp1", Hresp, 2'b01);
                check("slverr_ready1", Hreadyout, 1'b0);
                tick();
                check("slverr_resp2", Hresp, 2'b01);
                check("slverr_ready2", Hreadyout, 1'b1);
                tick();
                check("slverr_okay", Hresp, 2'b00);
            end else begin
                check("done_resp", Hresp, 2'b00);
            end
            check("done_ready", Hreadyout, 1'b1);
        end
        check("hrdata", Hrdata, v.exp_rdata);
    endtask

    initial begin
        vecs[0] = '{1'b1, 32'h8000_0010, 32'hA5A5_0001, 32'h0,          0, 1'b0, 1'b1, 3'b001, 32'h0};
        vecs[1] = '{1'b0, 32'h8400_0020, 32'h0,          32'h1234_5678, 2, 1'b0, 1'b1, 3'b010, 32'h1234_5678};
        vecs[2] = '{1'b1, 32'h8C00_0000, 32'h5555_5555, 32'h0,          0, 1'b0, 1'b0, 3'b000, 32'h1234_5678};
        vecs[3] = '{1'b0, 32'h8800_0000, 32'h0,          32'hDEAD_BEEF, 0, 1'b1, 1'b1, 3'b100, 32'h1234_5678};
        vecs[4] = '{1'b0, 32'h7FFF_FFFC, 32'h0,          32'h0,          0, 1'b0, 1'b0, 3'b000, 32'h1234_5678};
        vecs[5] = '{1'b0, 32'h8BFF_FFFC, 32'h0,          32'hCAFE_0002, 0, 1'b0, 1'b1, 3'b100, 32'hCAFE_0002};
        vecs[6] = '{1'b1, 32'h8400_0000, 32'h0000_FFFF, 32'h0,          1, 1'b0, 1'b1, 3'b010, 32'hCAFE_0002};
        vecs[7] = '{1'b0, 32'hFFFF_FFFF, 32'h0,          32'h0,          0, 1'b0, 1'b0, 3'b000, 32'hCAFE_0002};
        vecs[8] = '{1'b1, 32'h8000_0004, 32'h1111_2222, 32'h0,          0, 1'b1, 1'b1, 3'b001, 32'hCAFE_0002};

        Hresetn = 1'b0; Hwrite = 1'b0; Hreadyin = 1'b1; Htrans = 2'b00;
        Haddr = 32'h0; Hwdata = 32'h0; Prdata = 32'h0; Pready = 1'b0; Pslverr = 1'b0;
        #12;
        check("rst_hreadyout", Hreadyout, 1'b1);
        check("rst_hresp", Hresp, 2'b00);
        check("rst_hrdata", Hrdata, 32'h0);
        check("rst_paddr", Paddr, 32'h0);
        check("rst_pwdata", Pwdata, 32'h0);
        check("rst_pselx", Pselx, 3'b000);
        check("rst_penable", Penable, 1'b0);
        check("rst_pwrite", Pwrite, 1'b0);
        tick();
        Hresetn = 1'b1;
        tick();

        for (int i = 0; i < 9; i++) run_vec(vecs[i]);

        // back-to-back writes: next address presented in the IDLE cycle itself
        for (int k = 0; k < 4; k++) begin
            Hwrite = 1'b1; Haddr = 32'h8000_0000 + 32'(4 * k); Htrans = 2'b10; Hreadyin = 1'b1;
            tick();
            Htrans = 2'b00; Hwdata = 32'hB0B0_0000 + 32'(k);
            check("b2b_ready_low", Hreadyout, 1'b0);
            tick();
            check("b2b_setup_paddr", Paddr, 32'h8000_0000 + 32'(4 * k));
            check("b2b_setup_sel", Pselx, 3'b001);
            check("b2b_setup_penable", Penable, 1'b0);
            Pready = 1'b1;
            tick();
            check("b2b_access_penable", Penable, 1'b1);
            check("b2b_access_pwdata", Pwdata, 32'hB0B0_0000 + 32'(k));
            tick();
            Pready = 1'b0;
            check("b2b_done_ready", Hreadyout, 1'b1);
            check("b2b_done_sel", Pselx, 3'b000);
        end

        // BUSY and Hreadyin low are ignored; SEQ is accepted
        Htrans = 2'b01; Hwrite = 1'b0; Haddr = 32'h8000_0008;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("busy_sel", Pselx, 3'b000);
            check("busy_ready", Hreadyout, 1'b1);
        end
        Htrans = 2'b10; Hreadyin = 1'b0;
        tick();
        check("noready_sel", Pselx, 3'b000);
        check("noready_ready", Hreadyout, 1'b1);
        Htrans = 2'b11; Hreadyin = 1'b1;
        tick();
        Htrans = 2'b00;
        check("seq_setup_sel", Pselx, 3'b001);
        check("seq_setup_paddr", Paddr, 32'h8000_0008);
        tick();
        Pready = 1'b1; Prdata = 32'h5EC0_0001;
        tick();
        Pready = 1'b0;
        check("seq_hrdata", Hrdata, 32'h5EC0_0001);
        check("seq_ready", Hreadyout, 1'b1);

        // transfer presented during ERR2 is dropped
        Hwrite = 1'b0; Haddr = 32'h9000_0000; Htrans = 2'b10;
        tick();
        Htrans = 2'b00;
        check("err2seq_resp1", Hresp, 2'b01);
        tick();
        check("err2seq_resp2", Hresp, 2'b01);
        Haddr = 32'h8000_0000; Htrans = 2'b10;
        tick();
        Htrans = 2'b00;
        check("err2_ignored_sel", Pselx, 3'b000);
        check("err2_ignored_ready", Hreadyout, 1'b1);
        tick();
        check("err2_ignored_sel2", Pselx, 3'b000);

`ifdef AHB2APB_TIMEOUT_EN
        Hwrite = 1'b0; Haddr = 32'h8000_0000; Htrans = 2'b10;
        tick();
        Htrans = 2'b00;
        tick();
        check("to_access", Penable, 1'b1);
        for (int k = 0; k < 15; k++) begin
            tick();
            check("to_still_access", Penable, 1'b1);
        end
        tick();
        check("to_penable", Penable, 1'b0);
        check("to_sel", Pselx, 3'b000);
        check("to_resp1", Hresp, 2'b01);
        check("to_ready1", Hreadyout, 1'b0);
        Pready = 1'b1; Prdata = 32'h7777_7777;
        tick();
        Pready = 1'b0;
        check("to_resp2", Hresp, 2'b01);
        check("to_ready2", Hreadyout, 1'b1);
        tick();
        check("to_hrdata", Hrdata, 32'h5EC0_0001);
`endif

        // asynchronous reset during ACCESS
        Hwrite = 1'b0; Haddr = 32'h8400_0000; Htrans = 2'b10; Pready = 1'b0;
        tick();
        Htrans = 2'b00;
        tick();
        check("pre_rst_penable", Penable, 1'b1);
        check("pre_rst_sel", Pselx, 3'b010);
        #2 Hresetn = 1'b0;
        #1;
        check("mid_rst_sel", Pselx, 3'b000);
        check("mid_rst_penable", Penable, 1'b0);
        check("mid_rst_ready", Hreadyout, 1'b1);
        check("mid_rst_hrdata", Hrdata, 32'h0);
        check("mid_rst_paddr", Paddr, 32'h0);
        tick();
        Hresetn = 1'b1;
        tick();
        check("post_rst_sel", Pselx, 3'b000);
        check("post_rst_ready", Hreadyout, 1'b1);
        check("post_rst_resp", Hresp, 2'b00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
